// File: rtl/vector_element_streamer.sv
// Transmit side of the per-element vector strobe interface.
// Takes one 4-element vector per valid/ready handshake, buffers it and emits
// one element per enabled cycle, with a new_vector strobe, element index and
// last flag, plus a sync_clear pulse that realigns downstream index counters.
//
// state | meaning
// IDLE  | no vector buffered; in_ready high (unless abort/reset)
// SEND  | buffer holds a vector; ptr is the next element to emit
module vector_element_streamer #(
   parameter int DATA_WIDTH    = 8,
   parameter int VECTOR_LENGTH = 4
) (
   input  logic                                clock,
   input  logic                                clear_n,
   input  logic                                en,
   input  logic                                abort,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] in_vector,
   output logic [DATA_WIDTH-1:0]               element,
   output logic                                new_vector,
   output logic [1:0]                          vector_index,
   output logic                                last_element,
   output logic                                sync_clear,
   output logic                                busy
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                              state_q, state_d;
   logic [1:0]                          ptr_q, ptr_d;
   logic [VECTOR_LENGTH*DATA_WIDTH-1:0] buf_q, buf_d;
   logic [DATA_WIDTH-1:0]               element_q, element_d;
   logic [1:0]                          vidx_q, vidx_d;
   logic                                nv_q, nv_d;
   logic                                last_q, last_d;
   logic                                sclr_q, sclr_d;
   logic                                busy_q, busy_d;
   logic                                accept;
   logic [DATA_WIDTH-1:0]               elem_sel;

   // Ready is combinational so a new vector can be taken in the same cycle
   // the last element of the current one is emitted (gapless streaming).
   assign in_ready = clear_n && !abort &&
                     ((state_q == IDLE) || (en && (ptr_q == 2'd3)));
   assign accept   = in_valid && in_ready;
   assign elem_sel = buf_q[32'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];

   // Next-state and output decode; abort overrides accept and emission.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      buf_d     = buf_q;
      element_d = element_q;
      vidx_d    = vidx_q;
      nv_d      = 1'b0;
      last_d    = 1'b0;
      sclr_d    = 1'b0;
      if (abort) begin
         state_d = IDLE;
         ptr_d   = 2'd0;
         vidx_d  = 2'd0;
         sclr_d  = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  buf_d   = in_vector;
                  ptr_d   = 2'd0;
                  state_d = SEND;
               end
            end
            SEND: begin
               if (en) begin
                  element_d = elem_sel;
                  vidx_d    = ptr_q;
                  nv_d      = 1'b1;
                  last_d    = (ptr_q == 2'd3);
                  ptr_d     = ptr_q + 2'd1;
                  if (ptr_q == 2'd3) begin
                     if (accept) buf_d   = in_vector;
                     else        state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == SEND);
   end

   // State and output registers with synchronous active-low clear.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q   <= IDLE;
         ptr_q     <= 2'd0;
         buf_q     <= '0;
         element_q <= '0;
         vidx_q    <= 2'd0;
         nv_q      <= 1'b0;
         last_q    <= 1'b0;
         sclr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         buf_q     <= buf_d;
         element_q <= element_d;
         vidx_q    <= vidx_d;
         nv_q      <= nv_d;
         last_q    <= last_d;
         sclr_q    <= sclr_d;
         busy_q    <= busy_d;
      end
   end

   assign element      = element_q;
   assign new_vector   = nv_q;
   assign vector_index = vidx_q;
   assign last_element = last_q;
   assign sync_clear   = sclr_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_vector_element_streamer.sv
// Directed table plus a randomized scoreboard run for vector_element_streamer.
module tb_vector_element_streamer;

   logic        clock = 1'b0;
   logic        clear_n, en, abort, in_valid;
   logic        in_ready;
   logic [31:0] in_vector;
   logic [7:0]  element;
   logic        new_vector, last_element, sync_clear, busy;
   logic [1:0]  vector_index;

   int tests  = 0;
   int failed = 0;

   vector_element_streamer #(.DATA_WIDTH(8), .VECTOR_LENGTH(4)) dut (
      .clock        (clock),
      .clear_n      (clear_n),
      .en           (en),
      .abort        (abort),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_vector    (in_vector),
      .element      (element),
      .new_vector   (new_vector),
      .vector_index (vector_index),
      .last_element (last_element),
      .sync_clear   (sync_clear),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        cn, en, ab, v;
      logic [31:0] vec;
      logic        rdy, nv;
      logic [7:0]  el;
      logic [1:0]  idx;
      logic        last, sc, busy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic cn, logic e, logic ab, logic v, logic [31:0] vec,
                               logic rdy, logic nv, logic [7:0] el, logic [1:0] idx,
                               logic last, logic sc, logic b);
      vec_t r;
      r.cn = cn; r.en = e; r.ab = ab; r.v = v; r.vec = vec;
      r.rdy = rdy; r.nv = nv; r.el = el; r.idx = idx;
      r.last = last; r.sc = sc; r.busy = b;
      return r;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   // Outputs packed as {sync_clear, busy, last, new_vector, index, element}.
   function automatic logic [31:0] pack_out(logic sc, logic b, logic l, logic nv, logic [1:0] idx, logic [7:0] el);
      return {18'd0, sc, b, l, nv, idx, el};
   endfunction

   task automatic apply(input vec_t r, input int row);
      @(negedge clock);
      clear_n = r.cn; en = r.en; abort = r.ab; in_valid = r.v; in_vector = r.vec;
      #1;
      chk("in_ready", row, {31'd0, in_ready}, {31'd0, r.rdy});
      @(posedge clock);
      #1;
      chk("outputs", row, pack_out(sync_clear, busy, last_element, new_vector, vector_index, element),
          pack_out(r.sc, r.busy, r.last, r.nv, r.idx, r.el));
   endtask

   localparam logic [31:0] V1 = 32'h44332211;
   localparam logic [31:0] V2 = 32'h88776655;
   localparam logic [31:0] V3 = 32'hDDCCBBAA;
   localparam logic [31:0] V4 = 32'h04030201;

   logic [31:0] cur_vec, drv_vec;
   logic [7:0]  exp_el;
   logic        pv_nv, pv_sc, acc;
   logic [1:0]  pv_idx;
   logic [1:0]  cnt;

   initial begin
      clear_n = 1'b0; en = 1'b1; abort = 1'b0; in_valid = 1'b1; in_vector = V2;

      // cn en ab v  vec   rdy nv el     idx last sc busy
      // single vector
      tbl.push_back(mk(1,1,0,1,V1, 1,0,8'h00,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h11,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h22,1,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h33,2,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 1,1,8'h44,3,1,0,0));
      tbl.push_back(mk(1,1,0,0,V1, 1,0,8'h44,3,0,0,0));
      // back-to-back vectors, valid held
      tbl.push_back(mk(1,1,0,1,V2, 1,0,8'h44,3,0,0,1));
      tbl.push_back(mk(1,1,0,1,V3, 0,1,8'h55,0,0,0,1));
      tbl.push_back(mk(1,1,0,1,V3, 0,1,8'h66,1,0,0,1));
      tbl.push_back(mk(1,1,0,1,V3, 0,1,8'h77,2,0,0,1));
      tbl.push_back(mk(1,1,0,1,V3, 1,1,8'h88,3,1,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'hAA,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'hBB,1,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'hCC,2,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 1,1,8'hDD,3,1,0,0));
      tbl.push_back(mk(1,1,0,0,V1, 1,0,8'hDD,3,0,0,0));
      // stall after index 1
      tbl.push_back(mk(1,1,0,1,V4, 1,0,8'hDD,3,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h01,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h02,1,0,0,1));
      tbl.push_back(mk(1,0,0,0,V1, 0,0,8'h02,1,0,0,1));
      tbl.push_back(mk(1,0,0,1,V1, 0,0,8'h02,1,0,0,1));
      tbl.push_back(mk(1,0,0,0,V1, 0,0,8'h02,1,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h03,2,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 1,1,8'h04,3,1,0,0));
      tbl.push_back(mk(1,1,0,0,V1, 1,0,8'h04,3,0,0,0));
      // abort after index 1, then immediate new vector
      tbl.push_back(mk(1,1,0,1,V1, 1,0,8'h04,3,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h11,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h22,1,0,0,1));
      tbl.push_back(mk(1,1,1,1,V2, 0,0,8'h22,0,0,1,0));
      tbl.push_back(mk(1,1,0,1,V2, 1,0,8'h22,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h55,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h66,1,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h77,2,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 1,1,8'h88,3,1,0,0));
      // abort held while idle
      tbl.push_back(mk(1,1,1,0,V1, 0,0,8'h88,0,0,1,0));
      tbl.push_back(mk(1,1,1,0,V1, 0,0,8'h88,0,0,1,0));
      tbl.push_back(mk(1,1,0,0,V1, 1,0,8'h88,0,0,0,0));
      // reset mid-vector at index 2
      tbl.push_back(mk(1,1,0,1,V1, 1,0,8'h88,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h11,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h22,1,0,0,1));
      tbl.push_back(mk(1,1,0,0,V1, 0,1,8'h33,2,0,0,1));
      tbl.push_back(mk(0,1,0,1,V2, 0,0,8'h00,0,0,0,0));
      tbl.push_back(mk(0,1,0,1,V2, 0,0,8'h00,0,0,0,0));
      tbl.push_back(mk(1,1,0,0,V2, 1,0,8'h00,0,0,0,0));
      tbl.push_back(mk(1,1,0,0,V2, 1,0,8'h00,0,0,0,0));

      // initial reset
      repeat (2) @(posedge clock);
      #1;
      chk("reset_rdy", -1, {31'd0, in_ready}, 32'd0);
      chk("reset_out", -1, pack_out(sync_clear, busy, last_element, new_vector, vector_index, element),
          pack_out(0,0,0,0,2'd0,8'h00));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // randomized run with a downstream index counter model
      cnt = 2'd0; cur_vec = 32'd0;
      pv_nv = new_vector; pv_sc = sync_clear; pv_idx = vector_index;
      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         clear_n   = 1'b1;
         en        = ($urandom_range(0, 3) != 0);
         abort     = ($urandom_range(0, 19) == 0);
         in_valid  = ($urandom_range(0, 1) == 1);
         drv_vec   = $urandom;
         in_vector = drv_vec;
         #1;
         acc = in_valid && in_ready;
         @(posedge clock);
         #1;
         if (pv_sc) cnt = 2'd0;
         else if (pv_nv) begin
            cnt = cnt + 2'd1;
            chk("counter_align", c, {30'd0, cnt}, {30'd0, pv_idx + 2'd1});
         end
         if (new_vector) begin
            exp_el = cur_vec[8*vector_index +: 8];
            chk("rand_element", c, {24'd0, element}, {24'd0, exp_el});
            chk("rand_last", c, {31'd0, last_element}, {31'd0, (vector_index == 2'd3)});
         end else begin
            chk("rand_last_idle", c, {31'd0, last_element}, 32'd0);
         end
         if (acc) cur_vec = drv_vec;
         pv_nv = new_vector; pv_sc = sync_clear; pv_idx = vector_index;
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
